instruction_encode: RTL and testbench
=====================================

Name: instruction_encode

Overview:
Registered RISC-V RV32I instruction encoder and the inverse of the pipeline's instruction_decode stage. It accepts decoded fields (opcode, rd, rs1, rs2, func3, func7, imm) through a valid/ready handshake and packs them into a 32-bit instruction word. Each word is presented on a sequential instruction-memory write port with an auto-incrementing address. It serves as the program loader for imem and as the golden-word generator for decode-stage benches.

Parameters:
ADDR_WIDTH, 8, width of the word address counter; wraps at 2^ADDR_WIDTH.
BASE_ADDR, 0, address loaded into the counter on reset and on clear.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; 0 resets all state
clear  input  1  synchronous flush/restart, active-high
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept the bundle this cycle
opcode  input  7  instruction opcode
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
func3  input  3  funct3 field
func7  input  7  funct7 field
imm  input  32  immediate in decoder layout (unshifted, bit positions as decoded)
out_valid  output  1  out_instr/out_addr valid
out_ready  input  1  memory accepts the word
out_addr  output  ADDR_WIDTH  word address for out_instr
out_instr  output  32  encoded instruction
count  output  ADDR_WIDTH+1  words emitted since reset/clear; saturates at all-ones
illegal  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, illegal=0. Any in-flight word is lost.
- Input handshake: in_ready = (!out_valid || out_ready) && !clear. A bundle is accepted when in_valid && in_ready.
- Latency: the encoded word appears on out_instr, with out_valid=1, on the edge that accepts the bundle (1 cycle).
- Full throughput: back-to-back accepts are allowed while out_ready=1.
- Output handshake: a word retires on out_valid && out_ready. On retire, out_addr increments by 1 modulo 2^ADDR_WIDTH (all-ones wraps to 0) and count increments, saturating.
- Hold: while out_valid && !out_ready, out_instr and out_addr hold stable and in_ready=0.
- Simultaneous retire and accept: the new word loads and out_addr advances in the same cycle.
- clear=1 takes priority over every other event. Its effect at the edge: out_valid=0, out_addr=BASE_ADDR, count=0, illegal=0. No accept occurs that cycle, and a pending word is dropped without being counted.
- Encoding per opcode (bits not listed are 0):
  - R (0110011): func7[31:25] | rs2[24:20] | rs1[19:15] | func3[14:12] | rd[11:7] | opcode.
  - I (0010011, 0000011, 1100111): imm[11:0] -> [31:20], with rs1, func3, rd, opcode. rs2 and func7 are ignored.
  - S (0100011): imm[11:5] -> [31:25], rs2, rs1, func3, imm[4:0] -> [11:7], opcode.
  - B (1100011): imm[12] -> 31, imm[10:5] -> [30:25], rs2, rs1, func3, imm[4:1] -> [11:8], imm[11] -> 7, opcode.
  - U (0110111, 0010111): imm[31:12] -> [31:12], rd, opcode.
  - J (1101111): imm[20] -> 31, imm[10:1] -> [30:21], imm[11] -> 20, imm[19:12] -> [19:12], rd, opcode.
- Immediate bits outside the format's range are ignored. There is no range check.
- Misalignment: B or J with imm[0]=1 encodes normally (bit 0 dropped) and sets illegal.
- Unknown opcode: emits a NOP, 32'h00000013, at the next address and sets illegal.
- illegal is sticky until reset or clear. It is set at the accept edge.

Test Plan:
- R add x3,x1,x2 (op 0110011, rd=3, rs1=1, rs2=2, f3=0, f7=0) -> next cycle out_instr=0x002081B3, out_addr=0, out_valid=1; after retire, count=1.
- I addi x5,x0,-1 (op 0010011, rd=5, imm=0xFFFFFFFF) -> 0xFFF00293; B beq x1,x2,+8 (op 1100011, imm=8) -> 0x00208463.
- J jal x1,+2048 (op 1101111, rd=1, imm=0x800) -> 0x001000EF; repeat with imm=0x801 -> same word, illegal=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_instr/out_addr stable; after release, one retire per cycle. Stream 257 words with ADDR_WIDTH=8 -> out_addr wraps 255->0 and count reads 257.
- Opcode 0x7F -> out_instr=0x00000013 and illegal=1 held. Pulse clear -> illegal=0, count=0, out_addr=0, out_valid=0.
- Assert reset low mid-stream with out_valid=1 and out_ready=0 -> immediately (no clock edge) out_valid=0, out_instr=0, count=0. After release, the first accepted word goes to BASE_ADDR.

Source files
------------

// File: rtl/instruction_encode.sv
// RV32I field-bundle to instruction-word encoder with a sequential imem write port.
// A one-deep output register with a valid/ready handshake and an auto-incrementing word address.
module instruction_encode #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  illegal
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  function automatic logic [31:0] encode_word(
    input logic [6:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [31:0] w;
    w = '0;
    case (op)
      OP_R:                     w = {f7, f_rs2, f_rs1, f3, f_rd, op};
      OP_IMM, OP_LOAD, OP_JALR: w = {im[11:0], f_rs1, f3, f_rd, op};
      OP_STORE:                 w = {im[11:5], f_rs2, f_rs1, f3, im[4:0], op};
      OP_BRANCH:                w = {im[12], im[10:5], f_rs2, f_rs1, f3, im[4:1], im[11], op};
      OP_LUI, OP_AUIPC:         w = {im[31:12], f_rd, op};
      OP_JAL:                   w = {im[20], im[10:1], im[11], im[19:12], f_rd, op};
      default:                  w = NOP;
    endcase
    return w;
  endfunction

  // Unknown opcodes and odd branch/jump offsets are flagged; the word is still emitted.
  function automatic logic encode_bad(input logic [6:0] op, input logic im0);
    logic bad;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_LUI, OP_AUIPC: bad = 1'b0;
      OP_BRANCH, OP_JAL:                                          bad = im0;
      default:                                                    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                  vld_p1;
  logic [31:0]           instr_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [ADDR_WIDTH:0]   count_p1;
  logic                  illegal_p1;
  logic                  accept;
  logic                  retire;

  assign in_ready = (!vld_p1 || out_ready) && !clear;
  assign accept   = in_valid && in_ready;
  assign retire   = vld_p1 && out_ready;

  // Stage p0 -> p1: encode on accept, advance address and count on retire
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      addr_p1    <= BASE;
      count_p1   <= '0;
      illegal_p1 <= 1'b0;
    end else if (clear) begin
      vld_p1     <= 1'b0;
      addr_p1    <= BASE;
      count_p1   <= '0;
      illegal_p1 <= 1'b0;
    end else begin
      if (retire) begin
        addr_p1  <= addr_p1 + 1'b1;
        count_p1 <= sat_inc(count_p1);
      end
      if (accept) begin
        vld_p1     <= 1'b1;
        instr_p1   <= encode_word(opcode, rd, rs1, rs2, func3, func7, imm);
        illegal_p1 <= illegal_p1 | encode_bad(opcode, imm[0]);
      end else if (retire) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_addr  = addr_p1;
  assign count     = count_p1;
  assign illegal   = illegal_p1;

endmodule

// File: tb/tb_instruction_encode.sv
// Directed bench for instruction_encode: encodings, handshake, wrap, saturation, clear and reset.
module tb_instruction_encode;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_addr;
  logic [31:0] out_instr;
  logic [8:0]  count;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  instruction_encode #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .func3(func3), .func7(func7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .count(count), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; func3 = '0; func7 = '0; imm = '0;
    #3;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_illegal", 32'(illegal), 0);
    #20 reset = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 1);

    // add x3,x1,x2 held with out_ready low, then retired
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_addr", 32'(out_addr), 0);
    chk("add_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("add_retired_valid", 32'(out_valid), 0);
    chk("add_retired_addr", 32'(out_addr), 1);
    chk("add_retired_count", 32'(count), 1);

    // back-to-back stream; addi ignores rs2/func7
    drive(7'b0010011, 5'd5, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF);
    tick();
    chk("addi_instr", out_instr, 32'hFFF00293);
    chk("addi_addr", 32'(out_addr), 1);
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    tick();
    chk("beq_instr", out_instr, 32'h00208463);
    chk("beq_addr", 32'(out_addr), 2);
    chk("beq_count", 32'(count), 2);
    drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    tick();
    chk("sw_instr", out_instr, 32'h0020A223);
    drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    chk("lui_instr", out_instr, 32'h123452B7);
    drive(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    tick();
    chk("jal_neg_instr", out_instr, 32'hFFDFF06F);
    chk("jal_neg_illegal", 32'(illegal), 0);
    drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    tick();
    chk("beq_neg_instr", out_instr, 32'hFE000EE3);
    drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    tick();
    chk("jal_instr", out_instr, 32'h001000EF);
    chk("jal_illegal", 32'(illegal), 0);
    chk("jal_addr", 32'(out_addr), 7);
    chk("jal_count", 32'(count), 7);
    drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0801);
    tick();
    chk("jal_odd_instr", out_instr, 32'h001000EF);
    chk("jal_odd_illegal", 32'(illegal), 1);
    chk("jal_odd_addr", 32'(out_addr), 8);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_count", 32'(count), 9);
    chk("drain_addr", 32'(out_addr), 9);
    chk("drain_illegal_sticky", 32'(illegal), 1);

    // clear blocks accept and restarts
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    clear = 1'b1;
    #1;
    chk("clear_in_ready", 32'(in_ready), 0);
    tick();
    chk("clear_valid", 32'(out_valid), 0);
    chk("clear_illegal", 32'(illegal), 0);
    chk("clear_count", 32'(count), 0);
    chk("clear_addr", 32'(out_addr), 0);
    clear = 1'b0; in_valid = 1'b0;

    // unknown opcode -> NOP
    drive(7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF);
    tick();
    chk("unk_instr", out_instr, 32'h00000013);
    chk("unk_illegal", 32'(illegal), 1);
    chk("unk_addr", 32'(out_addr), 0);
    in_valid = 1'b0;
    tick();
    chk("unk_illegal_held", 32'(illegal), 1);
    chk("unk_count", 32'(count), 1);

    // backpressure for 3 cycles with a new bundle waiting
    out_ready = 1'b0;
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    drive(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_instr", out_instr, 32'h002081B3);
      chk("bp_addr", 32'(out_addr), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    tick();
    chk("bp_next_instr", out_instr, 32'hFFF00293);
    chk("bp_next_addr", 32'(out_addr), 2);
    chk("bp_next_count", 32'(count), 2);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_count", 32'(count), 3);

    // clear drops a pending word uncounted
    out_ready = 1'b0;
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    chk("drop_pending_valid", 32'(out_valid), 1);
    clear = 1'b1;
    tick();
    chk("drop_valid", 32'(out_valid), 0);
    chk("drop_count", 32'(count), 0);
    clear = 1'b0;

    // 257-word stream: address wrap, then continue into count saturation
    out_ready = 1'b1;
    drive(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    for (int k = 1; k <= 257; k++) begin
      tick();
      if (k == 256) begin
        chk("wrap_addr_255", 32'(out_addr), 255);
        chk("wrap_count_255", 32'(count), 255);
      end
    end
    chk("wrap_addr_0", 32'(out_addr), 0);
    chk("wrap_count_256", 32'(count), 256);
    in_valid = 1'b0;
    tick();
    chk("wrap_count_257", 32'(count), 257);
    chk("wrap_addr_1", 32'(out_addr), 1);
    in_valid = 1'b1;
    for (int k = 0; k < 260; k++) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_count", 32'(count), 511);
    chk("sat_addr", 32'(out_addr), 5);

    // async reset mid-stream while a word is held
    out_ready = 1'b0;
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_instr", out_instr, 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_addr", 32'(out_addr), 0);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    chk("post_rst_addr", 32'(out_addr), 0);
    chk("post_rst_instr", out_instr, 32'h002081B3);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
